// File: rtl/riscv_mem_pkg.sv
// Shared load/store encodings and LSU state type for the core's memory path.
package riscv_mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [2:0] STORE_OP_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] funct3);
        if (is_store) begin
            return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
        end
        return (funct3 == F3_LB) || (funct3 == F3_LH) || (funct3 == F3_LW) ||
               (funct3 == F3_LBU) || (funct3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extract and extend loaded bytes/halves, merge
// store bytes/halves into a previously read word.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  byte_sel,
    input  logic [2:0]  funct3,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [4:0]  byte_shift;
    logic [4:0]  half_shift;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign byte_shift = {byte_sel, 3'b000};
    assign half_shift = {byte_sel[1], 4'b0000};
    assign lane_byte  = 8'(word >> byte_shift);
    assign lane_half  = 16'(word >> half_shift);

    always_comb begin
        load_data = 32'h0;
        case (funct3)
            F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
            F3_LW:   load_data = word;
            F3_LBU:  load_data = {24'h0, lane_byte};
            F3_LHU:  load_data = {16'h0, lane_half};
            default: load_data = 32'h0;
        endcase
    end

    // Sub-word stores clear the target lane of the read word, then OR in the new lane.
    always_comb begin
        store_data = wdata;
        case (funct3)
            F3_SB:   store_data = (word & ~(32'h0000_00FF << byte_shift)) |
                                  (32'(wdata[7:0]) << byte_shift);
            F3_SH:   store_data = (word & ~(32'h0000_FFFF << half_shift)) |
                                  (32'(wdata[15:0]) << half_shift);
            default: store_data = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: turns funct3-encoded core requests into word-wide memory
// accesses with read-modify-write for SB/SH and extended load results.
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter logic [31:0] DATA_BASE  = 32'h0000_0000,
    parameter int          DATA_WORDS = 768
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic [31:0] mem_addr,
    output logic        mem_read_enable,
    output logic        mem_write_enable,
    output logic        read_from_reg,
    output logic [2:0]  store_operation,
    output logic [31:0] data_from_reg,
    input  logic [31:0] mem_read_data,
    output lsu_state_t  debug_state
);

    // Handshake: a request is taken on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, resp_valid is a single-cycle pulse in RESP.

    localparam logic [31:0] DATA_SPAN = 32'(DATA_WORDS * 4);

    lsu_state_t  state, next_state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic        store_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [31:0] rdata_q;

    logic [32:0] offset;
    logic        in_range;
    logic        misaligned;
    logic        req_err;
    logic        accept;
    logic [31:0] load_data;
    logic [31:0] store_data;

    // 33-bit difference so an address below DATA_BASE shows up as a borrow.
    assign offset   = {1'b0, req_addr} - {1'b0, DATA_BASE};
    assign in_range = !offset[32] && (offset[31:0] < DATA_SPAN);

    always_comb begin
        misaligned = 1'b0;
        case (req_funct3)
            F3_LH, F3_LHU: misaligned = req_addr[0];
            F3_LW:         misaligned = |req_addr[1:0];
            default:       misaligned = 1'b0;
        endcase
    end

    assign req_err = !funct3_legal(req_is_store, req_funct3) || misaligned || !in_range;
    assign accept  = req_valid && req_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            addr_q   <= 32'h0;
            funct3_q <= 3'b000;
            store_q  <= 1'b0;
            wdata_q  <= 32'h0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state <= next_state;
            if (accept) begin
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                store_q  <= req_is_store;
                wdata_q  <= req_wdata;
                err_q    <= req_err;
            end
            if (state == READ) begin
                rdata_q <= mem_read_data;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        next_state = RESP;
                    end else if (req_is_store && (req_funct3 == F3_SW)) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ:    next_state = store_q ? WRITE : RESP;
            WRITE:   next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    lsu_align u_align (
        .byte_sel   (addr_q[1:0]),
        .funct3     (funct3_q),
        .word       (rdata_q),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_comb begin
        req_ready        = 1'b0;
        resp_valid       = 1'b0;
        resp_rdata       = 32'h0;
        resp_error       = 1'b0;
        mem_addr         = 32'h0;
        mem_read_enable  = 1'b0;
        mem_write_enable = 1'b0;
        read_from_reg    = 1'b0;
        data_from_reg    = 32'h0;
        case (state)
            IDLE: req_ready = 1'b1;
            READ: begin
                mem_addr        = {addr_q[31:2], 2'b00};
                mem_read_enable = 1'b1;
            end
            WRITE: begin
                mem_addr         = {addr_q[31:2], 2'b00};
                mem_write_enable = 1'b1;
                read_from_reg    = 1'b1;
                data_from_reg    = store_data;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                resp_rdata = (store_q || err_q) ? 32'h0 : load_data;
            end
            default: req_ready = 1'b0;
        endcase
    end

    assign store_operation = STORE_OP_WORD;
    assign debug_state     = state;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads with extension, RMW stores,
// error rejection and asynchronous reset during a store write phase.
module tb_load_store_unit;
    import riscv_mem_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [31:0] mem_addr;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic        read_from_reg;
    logic [2:0]  store_operation;
    logic [31:0] data_from_reg;
    logic [31:0] mem_read_data;
    lsu_state_t  debug_state;

    logic [31:0] mem [0:1023];

    int checks = 0;
    int errors = 0;

    int          lat;
    int          reads;
    int          writes;
    logic [31:0] got_rdata;
    logic        got_error;
    logic        ready_in_resp;
    logic        ready_after;
    logic        resp_after;
    logic [31:0] wr_data;
    logic [31:0] wr_addr;
    logic        wr_rfr;
    logic [2:0]  wr_op;
    logic [31:0] rd_addr;

    load_store_unit dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_is_store     (req_is_store),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .mem_addr         (mem_addr),
        .mem_read_enable  (mem_read_enable),
        .mem_write_enable (mem_write_enable),
        .read_from_reg    (read_from_reg),
        .store_operation  (store_operation),
        .data_from_reg    (data_from_reg),
        .mem_read_data    (mem_read_data),
        .debug_state      (debug_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_read_data = mem[mem_addr[11:2]];

    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_addr[11:2]] <= data_from_reg;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic present(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd);
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = st;
        req_funct3   = f3;
        req_addr     = addr;
        req_wdata    = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_is_store = 1'($urandom_range(0, 1));
        req_funct3   = 3'($urandom_range(0, 7));
        req_addr     = $urandom();
        req_wdata    = $urandom();
    endtask

    task automatic do_txn(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd);
        present(st, f3, addr, wd);
        lat = 0; reads = 0; writes = 0;
        got_rdata = 32'hx; got_error = 1'bx; ready_in_resp = 1'bx;
        wr_data = 32'h0; wr_addr = 32'h0; wr_rfr = 1'b0; wr_op = 3'b000; rd_addr = 32'h0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (mem_read_enable) begin
                reads++;
                rd_addr = mem_addr;
            end
            if (mem_write_enable) begin
                writes++;
                wr_data = data_from_reg;
                wr_addr = mem_addr;
                wr_rfr  = read_from_reg;
                wr_op   = store_operation;
            end
            if (resp_valid) begin
                lat           = i;
                got_rdata     = resp_rdata;
                got_error     = resp_error;
                ready_in_resp = req_ready;
                break;
            end
        end
        @(negedge clk);
        ready_after = req_ready;
        resp_after  = resp_valid;
    endtask

    task automatic expect_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] exp);
        do_txn(1'b0, f3, addr, 32'h0);
        check({tag, "_latency"}, 32'(lat), 32'd2);
        check({tag, "_rdata"}, got_rdata, exp);
        check({tag, "_error"}, 32'(got_error), 32'd0);
        check({tag, "_reads"}, 32'(reads), 32'd1);
        check({tag, "_rd_addr"}, rd_addr, {addr[31:2], 2'b00});
        check({tag, "_writes"}, 32'(writes), 32'd0);
        check({tag, "_ready_in_resp"}, 32'(ready_in_resp), 32'd0);
        check({tag, "_ready_after"}, 32'(ready_after), 32'd1);
        check({tag, "_single_pulse"}, 32'(resp_after), 32'd0);
    endtask

    task automatic expect_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] exp_word,
                                input int exp_reads, input int exp_lat);
        do_txn(1'b1, f3, addr, wd);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_reads"}, 32'(reads), 32'(exp_reads));
        check({tag, "_writes"}, 32'(writes), 32'd1);
        check({tag, "_wr_data"}, wr_data, exp_word);
        check({tag, "_wr_addr"}, wr_addr, {addr[31:2], 2'b00});
        check({tag, "_read_from_reg"}, 32'(wr_rfr), 32'd1);
        check({tag, "_store_op"}, 32'(wr_op), 32'h2);
        check({tag, "_rdata"}, got_rdata, 32'h0);
        check({tag, "_error"}, 32'(got_error), 32'd0);
        check({tag, "_mem"}, mem[addr[11:2]], exp_word);
        check({tag, "_ready_after"}, 32'(ready_after), 32'd1);
    endtask

    task automatic expect_error(input string tag, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr);
        do_txn(st, f3, addr, 32'hCAFE_F00D);
        check({tag, "_latency"}, 32'(lat), 32'd1);
        check({tag, "_error"}, 32'(got_error), 32'd1);
        check({tag, "_rdata"}, got_rdata, 32'h0);
        check({tag, "_reads"}, 32'(reads), 32'd0);
        check({tag, "_writes"}, 32'(writes), 32'd0);
        check({tag, "_ready_after"}, 32'(ready_after), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[5] = 32'hFFFF_FFE0;
        mem[6] = 32'h1122_3344;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        reset_n      = 1'b0;

        #2;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_error", 32'(resp_error), 32'd0);
        check("rst_mem_re", 32'(mem_read_enable), 32'd0);
        check("rst_mem_we", 32'(mem_write_enable), 32'd0);
        check("rst_read_from_reg", 32'(read_from_reg), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_data_from_reg", data_from_reg, 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Loads with sign/zero extension across lanes.
        expect_load("lb_14", F3_LB, 32'h14, 32'hFFFF_FFE0);
        expect_load("lbu_14", F3_LBU, 32'h14, 32'h0000_00E0);
        expect_load("lhu_16", F3_LHU, 32'h16, 32'h0000_FFFF);
        expect_load("lh_16", F3_LH, 32'h16, 32'hFFFF_FFFF);
        expect_load("lb_17", F3_LB, 32'h17, 32'hFFFF_FFFF);
        expect_load("lw_18", F3_LW, 32'h18, 32'h1122_3344);
        expect_load("lh_18", F3_LH, 32'h18, 32'h0000_3344);
        expect_load("lbu_1a", F3_LBU, 32'h1A, 32'h0000_0022);
        expect_load("lw_last", F3_LW, 32'hBFC, 32'h0000_0000);

        // Read-modify-write and plain word stores.
        expect_store("sb_19", F3_SB, 32'h19, 32'h0000_00AB, 32'h1122_AB44, 1, 3);
        mem[6] = 32'h1122_3344;
        expect_store("sh_1a", F3_SH, 32'h1A, 32'h0000_BEEF, 32'hBEEF_3344, 1, 3);
        expect_store("sw_20", F3_SW, 32'h20, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 2);
        expect_load("lw_20", F3_LW, 32'h20, 32'hDEAD_BEEF);

        // Rejected requests never touch memory.
        expect_error("lw_mis", 1'b0, F3_LW, 32'h21);
        expect_error("sh_mis", 1'b1, F3_SH, 32'h1B);
        expect_error("lw_range", 1'b0, F3_LW, 32'h0C00);
        expect_error("lh_mis", 1'b0, F3_LH, 32'h15);
        expect_error("ld_f3_011", 1'b0, 3'b011, 32'h14);
        expect_error("st_f3_100", 1'b1, 3'b100, 32'h14);
        check("err_mem_untouched", mem[8], 32'hDEAD_BEEF);

        // Reset while an SB is in its write phase.
        mem[7] = 32'h5566_7788;
        present(1'b1, F3_SB, 32'h1C, 32'h0000_0099);
        @(negedge clk);
        check("rmw_read_phase", 32'(mem_read_enable), 32'd1);
        @(negedge clk);
        check("rmw_write_phase", 32'(mem_write_enable), 32'd1);
        check("rmw_write_data", data_from_reg, 32'h5566_7799);
        reset_n = 1'b0;
        #1;
        check("arst_mem_we", 32'(mem_write_enable), 32'd0);
        check("arst_read_from_reg", 32'(read_from_reg), 32'd0);
        check("arst_data_from_reg", data_from_reg, 32'h0);
        check("arst_mem_addr", mem_addr, 32'h0);
        check("arst_req_ready", 32'(req_ready), 32'd1);
        check("arst_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("arst_no_rewrite", 32'(mem_write_enable), 32'd0);
            check("arst_no_resp", 32'(resp_valid), 32'd0);
        end
        check("arst_mem_kept", mem[7], 32'h5566_7788);
        check("arst_ready_release", 32'(req_ready), 32'd1);
        expect_load("lw_after_rst", F3_LW, 32'h1C, 32'h5566_7788);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's execute/writeback stage and the unified memory block.
- Converts RISC-V load/store requests (funct3-encoded) into word-wide memory accesses.
- Performs read-modify-write for SB/SH and extracts plus sign/zero-extends loaded bytes and halves.
- Flags misaligned and out-of-range accesses without touching memory; valid/ready handshake toward the core.

Parameters:
- DATA_BASE, 32'h0000_0000, byte address of data memory word 0
- DATA_WORDS, 768, number of 32-bit data words; valid range is [DATA_BASE, DATA_BASE+4*DATA_WORDS)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  core presents a request
- req_ready  out  1  LSU can accept (high only in IDLE)
- req_is_store  in  1  1=store, 0=load
- req_funct3  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
- req_addr  in  32  byte address (rs1+imm)
- req_wdata  in  32  rs2 value for stores
- resp_valid  out  1  one-cycle pulse, result ready
- resp_rdata  out  32  extended load data (0 for stores/errors)
- resp_error  out  1  misaligned, out-of-range, or illegal funct3
- mem_addr  out  32  word-aligned address to memory
- mem_read_enable  out  1  memory read strobe
- mem_write_enable  out  1  memory write strobe
- read_from_reg  out  1  asserted with mem_write_enable
- store_operation  out  3  always 3'b010 (word write; merging done here)
- data_from_reg  out  32  merged write word
- mem_read_data  in  32  combinational read data from memory

Behaviour:
- Reset (async, reset_n=0): state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_error=0; all mem_* strobes 0, mem_addr=0, data_from_reg=0. Takes effect immediately, even mid-transaction; an interrupted store never asserts mem_write_enable again.
- Request latch: request accepted when req_valid & req_ready at a rising edge. Addr, funct3, is_store and wdata are registered; inputs are ignored afterwards.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE transitions on accept:
  - error -> RESP
  - load -> READ
  - SW -> WRITE
  - SB/SH -> READ
- READ:
  - Drive mem_addr = {addr[31:2],2'b00} and mem_read_enable=1.
  - Capture mem_read_data at the edge.
  - Load -> RESP; SB/SH -> WRITE.
- WRITE:
  - Drive mem_write_enable=1, read_from_reg=1, store_operation=3'b010, and the same word address.
  - Drive data_from_reg: SW = wdata; SB = captured word with byte addr[1:0] replaced by wdata[7:0]; SH = captured word with half addr[1] replaced by wdata[15:0].
  - -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Strobes and data outputs are registered/decoded from state; they are 0 outside their state.
- Latency (accept edge to resp_valid): load 2 cycles, SW 2, SB/SH 3, error 1.
- Load extraction:
  - LB/LBU: byte at addr[1:0], sign/zero extended.
  - LH/LHU: half at addr[1], sign/zero extended.
  - LW: full word.
- Errors: resp_error=1 on any of the following, with no mem strobe asserted:
  - LH/LHU/SH with addr[0]=1
  - LW/SW with addr[1:0]!=0
  - address outside the valid range
  - funct3 not listed above (loads 011/110/111, stores >=011)
- Back-to-back: req_ready returns high the cycle after RESP. No request is accepted while resp_valid=1.

Decomposition:
- Shared package riscv_mem_pkg holds:
  - funct3 localparams (LB/LH/LW/LBU/LHU, SB/SH/SW)
  - STORE_OP_WORD=3'b010
  - lsu_state_t enum {IDLE,READ,WRITE,RESP}
- One sub-module, lsu_align: purely combinational byte/half extract+extend and store merge, driven by addr[1:0], funct3, captured word and wdata.

Test Plan:
1. Word 5 preloaded 32'hFFFF_FFE0; LB addr 0x14 -> resp_rdata=32'hFFFF_FFE0 after 2 cycles; LBU -> 32'h0000_00E0; LHU addr 0x16 -> 32'h0000_FFFF.
2. Word 6 = 32'h1122_3344; SB wdata 32'hAB addr 0x19 -> one READ then one WRITE with data_from_reg=32'h1122_AB44; resp_valid 3 cycles after accept.
3. SH wdata 32'hBEEF addr 0x1A on 32'h1122_3344 -> write 32'hBEEF_3344. SW 32'hDEAD_BEEF addr 0x20 -> no read strobe, single write.
4. LW addr 0x21, SH addr 0x1B, LW addr 0x0C00 -> resp_error=1 after 1 cycle, mem strobes never asserted, resp_rdata=0.
5. Drop reset_n while in WRITE of an SB -> outputs reset immediately, mem_write_enable=0; after release, req_ready=1 and the next LW completes normally.
